rv_stream_sink_checker: RTL and testbench
=========================================

// Module: rv_stream_sink_checker
// PURPOSE
//   Downstream (slave) endpoint of the ready/valid stream interface. Drives in_ready per a
//   selectable backpressure pattern, accepts beats, checks that data is a +1 incrementing
//   sequence, and checks upstream protocol rules (hold valid and data while stalled).
//   Sits at the output of ready_valid_proxy and similar stages in self-checking benches and FPGA tests.
// PARAMETERS
//   DATA_W      28       stream data width
//   FIRST_VAL   1        expected value of the first beat after start
//   TIMEOUT     255      consecutive no-beat RUN cycles before a timeout fail (>=2)
//   CNT_W       16       width of beat_cnt
//   LFSR_SEED   16'hACE1 nonzero seed for the RANDOM ready pattern
// PORTS
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       pulse: begin or restart a check run (ignored in RUN)
//   mode        in   2       ready pattern, sampled on start: 0 ALWAYS, 1 TOGGLE, 2 RANDOM, 3 BURST
//   end_val     in   DATA_W  last expected value; sampled on start
//   in_data     in   DATA_W  stream data
//   in_valid    in   1       stream valid
//   in_ready    out  1       stream ready, flop-driven (no comb path from in_valid/in_data)
//   busy        out  1       state==RUN
//   done        out  1       state==DONE (sticky until start)
//   fail        out  1       state==FAIL (sticky until start)
//   err_code    out  2       0 none, 1 data mismatch, 2 timeout, 3 protocol violation
//   err_expect  out  DATA_W  expected value at the failure
//   err_got     out  DATA_W  in_data at the failure (0 for timeout)
//   beat_cnt    out  CNT_W   accepted beats this run; saturates at all-ones
// BEHAVIOUR
//   Reset: state IDLE; in_ready, busy, done, fail = 0; err_code, err_expect, err_got, beat_cnt = 0;
//     LFSR = LFSR_SEED. Reset mid-run aborts immediately. No beat is accepted in the reset cycle.
//   Beat = in_valid & in_ready on a rising edge. in_ready is 0 outside RUN.
//   FSM IDLE/RUN/DONE/FAIL:
//     IDLE|DONE|FAIL + start -> RUN: expect=FIRST_VAL, beat_cnt=0, stall=0, err fields cleared,
//       mode/end_val latched, pattern phase reset. LFSR is not reseeded; it advances only in RUN.
//     RUN, beat, in_data!=expect -> FAIL, err 1; capture expect/in_data.
//     RUN, beat, in_data==expect==end_val -> DONE (beat counted).
//     RUN, beat, match otherwise -> expect+1 (mod 2^DATA_W), beat_cnt+1.
//     RUN, no beat, stall==TIMEOUT-1 -> FAIL, err 2, err_expect=expect.
//     RUN protocol check: previous cycle had in_valid=1 and in_ready=0, and this cycle has
//       in_valid=0 or changed in_data -> FAIL, err 3. The check is suppressed on the first RUN cycle.
//     Priority in one cycle: protocol(3) > mismatch(1) > timeout(2).
//   Ready pattern (registered; value applies the cycle after it is computed):
//     First RUN cycle after start: in_ready=1 for every mode.
//     ALWAYS: 1. TOGGLE: 1,0,1,0,... from the first RUN cycle.
//     RANDOM: LFSR bit0 (x^16+x^14+x^13+x^11), advanced every RUN cycle.
//     BURST: 4 cycles 1, then 4 cycles 0, repeating.
//   Stall counter: reset to 0 on a beat; increments on each RUN cycle without a beat;
//     does not wrap before the timeout.
//   When leaving RUN, in_ready is 0 from the next cycle on. No beat is accepted in DONE/FAIL.
// STRUCTURE
//   Package rv_chk_pkg: state encodings, MODE_* and ERR_* localparams, LFSR taps.
//   Sub-module rv_ready_pattern_gen (clk, rst_n, restart, run, mode -> ready_nxt), which
//     holds the LFSR and the toggle/burst phase. The checker FSM, counters and error capture
//     stay in the top level.
// TESTING
//   1 mode0, end_val=20, source sends 1..20 back-to-back -> done at the beat of 20,
//     beat_cnt=20, in_ready=0 the next cycle.
//   2 mode1, source valid always high, data 1..10 -> beats only on in_ready=1 cycles,
//     done, beat_cnt=10.
//   3 mode0, source sends 1,2,4 -> fail, err_code=1, err_expect=3, err_got=4, beat_cnt=2.
//   4 mode3, source sends 5 beats then idles -> fail exactly TIMEOUT cycles after the
//     last beat, err_code=2, err_expect=6.
//   5 mode1, source drops valid (or changes data 7->8) while in_ready=0 -> fail,
//     err_code=3, even if the new data matches the expected value.
//   6 mode2, end_val=255, random source valid, rst_n pulse mid-run, then start again ->
//     all outputs at reset values; second run reaches done with beat_cnt=255.

Source files
------------

// File: rtl/rv_chk_pkg.sv
// Shared encodings for the ready/valid sink checker: FSM states, ready modes, error codes, LFSR step.
// Pure declarations; no latency or backpressure of its own.
package rv_chk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [1:0] MODE_ALWAYS = 2'd0;
  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_RANDOM = 2'd2;
  localparam logic [1:0] MODE_BURST  = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DATA    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_PROTO   = 2'd3;

  // Galois form of x^16+x^14+x^13+x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/rv_ready_pattern_gen.sv
// Computes next-cycle in_ready for the selected pattern; holds LFSR and toggle/burst phase.
// Combinational output from registered phase; the caller registers it (one cycle ahead).
module rv_ready_pattern_gen
  import rv_chk_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       run,
  input  logic [1:0] mode,
  output logic       ready_nxt
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  phase_q, phase_d, phase_inc;

  // phase_q is the index of the current RUN cycle (mod 8); ready_nxt targets index+1
  assign phase_inc = phase_q + 3'd1;

  always_comb begin
    lfsr_d  = lfsr_q;
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (run) begin
      lfsr_d  = lfsr_step(lfsr_q);
      phase_d = phase_inc;
    end
  end

  always_comb begin
    case (mode)
      MODE_TOGGLE: ready_nxt = phase_q[0];
      MODE_RANDOM: ready_nxt = lfsr_q[0];
      MODE_BURST:  ready_nxt = ~phase_inc[2];
      default:     ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= LFSR_SEED;
      phase_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/rv_stream_sink_checker.sv
// Ready/valid sink: drives a patterned in_ready, checks +1 data sequence and source hold rules.
// in_ready is registered; beats complete on the edge with valid&ready, results appear the next cycle.
module rv_stream_sink_checker
  import rv_chk_pkg::*;
#(
  parameter int unsigned       DATA_W    = 28,
  parameter logic [DATA_W-1:0] FIRST_VAL = {{(DATA_W-1){1'b0}}, 1'b1},
  parameter int unsigned       TIMEOUT   = 255,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [15:0]       LFSR_SEED = 16'hACE1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] end_val,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] err_expect,
  output logic [DATA_W-1:0] err_got,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int unsigned        STALL_W    = $clog2(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] end_val_q, end_val_d;
  logic [DATA_W-1:0] expect_q, expect_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [DATA_W-1:0] err_expect_q, err_expect_d;
  logic [DATA_W-1:0] err_got_q, err_got_d;
  logic              first_q, first_d;
  logic              prev_stall_q;
  logic [DATA_W-1:0] prev_data_q;

  logic run, restart, beat, proto_err, data_err, tmo_err, ready_nxt;

  assign run     = (state_q == ST_RUN);
  assign restart = start & ~run;
  assign beat    = run & in_valid & in_ready_q;

  // The cycle after start still sees IDLE-era stall history, so it is exempt
  assign proto_err = run & ~first_q & prev_stall_q & (~in_valid | (in_data != prev_data_q));
  assign data_err  = beat & (in_data != expect_q);
  assign tmo_err   = run & ~beat & (stall_q == STALL_LAST);

  rv_ready_pattern_gen #(.LFSR_SEED(LFSR_SEED)) u_pat (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .run       (run),
    .mode      (mode_q),
    .ready_nxt (ready_nxt)
  );

  always_comb begin
    state_d      = state_q;
    in_ready_d   = 1'b0;
    mode_d       = mode_q;
    end_val_d    = end_val_q;
    expect_d     = expect_q;
    beat_cnt_d   = beat_cnt_q;
    stall_d      = stall_q;
    err_code_d   = err_code_q;
    err_expect_d = err_expect_q;
    err_got_d    = err_got_q;
    first_d      = first_q;
    if (restart) begin
      state_d      = ST_RUN;
      in_ready_d   = 1'b1;
      mode_d       = mode;
      end_val_d    = end_val;
      expect_d     = FIRST_VAL;
      beat_cnt_d   = '0;
      stall_d      = '0;
      err_code_d   = ERR_NONE;
      err_expect_d = '0;
      err_got_d    = '0;
      first_d      = 1'b1;
    end else if (run) begin
      first_d    = 1'b0;
      in_ready_d = ready_nxt;
      if (proto_err) begin
        state_d      = ST_FAIL;
        err_code_d   = ERR_PROTO;
        err_expect_d = expect_q;
        err_got_d    = in_data;
      end else if (data_err) begin
        state_d      = ST_FAIL;
        err_code_d   = ERR_DATA;
        err_expect_d = expect_q;
        err_got_d    = in_data;
      end else if (beat) begin
        stall_d = '0;
        if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (expect_q == end_val_q) state_d = ST_DONE;
        else expect_d = expect_q + DATA_W'(1);
      end else if (tmo_err) begin
        state_d      = ST_FAIL;
        err_code_d   = ERR_TIMEOUT;
        err_expect_d = expect_q;
        err_got_d    = '0;
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
      if (state_d != ST_RUN) in_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      mode_q       <= MODE_ALWAYS;
      end_val_q    <= '0;
      expect_q     <= '0;
      beat_cnt_q   <= '0;
      stall_q      <= '0;
      err_code_q   <= ERR_NONE;
      err_expect_q <= '0;
      err_got_q    <= '0;
      first_q      <= 1'b0;
      prev_stall_q <= 1'b0;
      prev_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      mode_q       <= mode_d;
      end_val_q    <= end_val_d;
      expect_q     <= expect_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_q      <= stall_d;
      err_code_q   <= err_code_d;
      err_expect_q <= err_expect_d;
      err_got_q    <= err_got_d;
      first_q      <= first_d;
      prev_stall_q <= in_valid & ~in_ready_q;
      prev_data_q  <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = run;
  assign done       = (state_q == ST_DONE);
  assign fail       = (state_q == ST_FAIL);
  assign err_code   = err_code_q;
  assign err_expect = err_expect_q;
  assign err_got    = err_got_q;
  assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_rv_stream_sink_checker.sv
// Directed bench for rv_stream_sink_checker: table of source scenarios plus protocol/reset sequences.
module tb_rv_stream_sink_checker;

  localparam int DATA_W  = 28;
  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [DATA_W-1:0] end_val = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, busy, done, fail;
  logic [1:0]        err_code;
  logic [DATA_W-1:0] err_expect, err_got;
  logic [CNT_W-1:0]  beat_cnt;

  int total = 0;
  int bad   = 0;

  rv_stream_sink_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .end_val    (end_val),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .err_code   (err_code),
    .err_expect (err_expect),
    .err_got    (err_got),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        mode;
    logic [DATA_W-1:0] end_val;
    int                n_send;
    int                bad_idx;   // beat index from which the source skips one value (0 = never)
    bit                rnd_valid;
    logic              exp_done;
    logic              exp_fail;
    logic [1:0]        exp_err;
    logic [DATA_W-1:0] exp_expect;
    logic [DATA_W-1:0] exp_got;
    logic [CNT_W-1:0]  exp_cnt;
  } rec_t;

  function automatic rec_t mk(input logic [1:0] m, input int ev, input int n, input int bi,
                              input bit rnd, input logic d, input logic f, input logic [1:0] e,
                              input int ee, input int eg, input int ec);
    rec_t r;
    r.mode = m; r.end_val = DATA_W'(ev); r.n_send = n; r.bad_idx = bi; r.rnd_valid = rnd;
    r.exp_done = d; r.exp_fail = f; r.exp_err = e;
    r.exp_expect = DATA_W'(ee); r.exp_got = DATA_W'(eg); r.exp_cnt = CNT_W'(ec);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] src_val(input rec_t r, input int i);
    int v;
    v = i + 1 + ((r.bad_idx > 0 && i >= r.bad_idx) ? 1 : 0);
    return DATA_W'(v);
  endfunction

  function automatic logic exp_ready(input logic [1:0] m, input int k);
    case (m)
      2'd1:    return (k % 2) == 0;
      2'd3:    return ((k / 4) % 2) == 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_rec(input rec_t r, input string nm);
    int   sent, k, last_beat, pat_bad;
    logic bt;
    sent = 0; k = 0; last_beat = -1; pat_bad = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    mode     = r.mode;
    end_val  = r.end_val;
    in_data  = src_val(r, 0);
    in_valid = r.rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(done | fail) && k < 4000) begin
      if (r.mode != 2'd2 && in_ready !== exp_ready(r.mode, k)) pat_bad++;
      bt = in_valid & in_ready;
      @(posedge clk); #1;
      if (bt) begin
        sent++;
        last_beat = k;
        in_data   = src_val(r, sent);
        in_valid  = (sent < r.n_send) ? (r.rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      end else if (r.rnd_valid && !in_valid && sent < r.n_send) begin
        in_valid = 1'($urandom_range(0, 1));
      end
      k++;
    end
    chk({nm, " finished"}, 32'(k < 4000), 32'd1);
    chk({nm, " ready_pattern_errs"}, 32'(pat_bad), 32'd0);
    chk({nm, " done"}, 32'(done), 32'(r.exp_done));
    chk({nm, " fail"}, 32'(fail), 32'(r.exp_fail));
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " in_ready_after_end"}, 32'(in_ready), 32'd0);
    chk({nm, " err_code"}, 32'(err_code), 32'(r.exp_err));
    chk({nm, " err_expect"}, 32'(err_expect), 32'(r.exp_expect));
    chk({nm, " err_got"}, 32'(err_got), 32'(r.exp_got));
    chk({nm, " beat_cnt"}, 32'(beat_cnt), 32'(r.exp_cnt));
    if (r.exp_err == 2'd2) chk({nm, " timeout_gap"}, 32'(k - last_beat - 1), 32'(TIMEOUT));
    // done/fail must hold with no further beats
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk({nm, " sticky_cnt"}, 32'(beat_cnt), 32'(r.exp_cnt));
    chk({nm, " sticky_ready"}, 32'(in_ready), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " done"}, 32'(done), 32'd0);
    chk({nm, " fail"}, 32'(fail), 32'd0);
    chk({nm, " err_code"}, 32'(err_code), 32'd0);
    chk({nm, " err_expect"}, 32'(err_expect), 32'd0);
    chk({nm, " err_got"}, 32'(err_got), 32'd0);
    chk({nm, " beat_cnt"}, 32'(beat_cnt), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t tbl[7];
    logic bt;
    tbl[0] = mk(2'd0,  20, 20, 0, 1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 20);
    tbl[1] = mk(2'd1,  10, 10, 0, 1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 10);
    tbl[2] = mk(2'd0, 100,  3, 2, 1'b0, 1'b0, 1'b1, 2'd1, 3, 4,  2);
    tbl[3] = mk(2'd3, 100,  5, 0, 1'b0, 1'b0, 1'b1, 2'd2, 6, 0,  5);
    tbl[4] = mk(2'd3,  12, 12, 0, 1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 12);
    tbl[5] = mk(2'd2,  30, 30, 0, 1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 30);
    tbl[6] = mk(2'd1,   3,  3, 0, 1'b1, 1'b1, 1'b0, 2'd0, 0, 0,  3);

    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("idle");

    for (int i = 0; i < 7; i++) run_rec(tbl[i], $sformatf("rec%0d", i));

    // Valid dropped while stalled
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd1; end_val = 28'd100; in_valid = 1'b1; in_data = 28'd1;
    @(posedge clk); #1; start = 1'b0;
    chk("drop k0 ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_data = 28'd2;
    chk("drop k1 ready", 32'(in_ready), 32'd0);
    chk("drop k1 cnt", 32'(beat_cnt), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1; in_data = 28'd3;
    chk("drop k3 ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drop fail", 32'(fail), 32'd1);
    chk("drop err_code", 32'(err_code), 32'd3);
    chk("drop err_expect", 32'(err_expect), 32'd3);
    chk("drop err_got", 32'(err_got), 32'd3);
    chk("drop beat_cnt", 32'(beat_cnt), 32'd2);

    // Data changed under stall to the value the checker wanted: still a protocol error
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd1; end_val = 28'd100; in_valid = 1'b1; in_data = 28'd1;
    @(posedge clk); #1; start = 1'b0;
    chk("chg restart busy", 32'(busy), 32'd1);
    chk("chg restart err_code", 32'(err_code), 32'd0);
    chk("chg restart cnt", 32'(beat_cnt), 32'd0);
    @(posedge clk); #1; in_data = 28'd3;
    @(posedge clk); #1; in_data = 28'd2;
    @(posedge clk); #1;
    chk("chg fail", 32'(fail), 32'd1);
    chk("chg err_code", 32'(err_code), 32'd3);
    chk("chg err_expect", 32'(err_expect), 32'd2);
    chk("chg err_got", 32'(err_got), 32'd2);
    chk("chg beat_cnt", 32'(beat_cnt), 32'd1);

    // Random run aborted by reset, then a full 255-beat run
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd2; end_val = 28'd255; in_valid = 1'b1; in_data = 28'd1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bt = in_valid & in_ready;
      @(posedge clk); #1;
      if (bt) begin
        in_data  = in_data + 28'd1;
        in_valid = 1'($urandom_range(0, 1));
      end else if (!in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
      end
    end
    chk("abort busy", 32'(busy), 32'd1);
    rst_n = 1'b0; in_valid = 1'b0;
    #2;
    chk_reset_vals("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_rec(mk(2'd2, 255, 255, 0, 1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 255), "rand255");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
